// File: rtl/ampel_timer.sv
`default_nettype none
// ============================================================================
// Module      : ampel_timer
// Description : Phase countdown timer for the traffic-light controller.
//               The light-sequencing FSM loads a phase length (in whole time
//               ticks). A prescaler divides clk down to ticks, and the timer
//               reports the remaining ticks and phase completion back to the
//               FSM.
//
// Parameters  : TICK_DIV  clk cycles per time tick (>= 1)
//               DIV_W     prescaler width, 2**DIV_W >= TICK_DIV
//
// Ports       : clk    in   1  clock
//               reset  in   1  synchronous, active-high reset
//               load   in   1  load request (sampled every edge)
//               init   in   5  phase length in ticks, valid with load
//               count  out  5  remaining whole ticks in the phase
//               ready  out  1  phase finished (level, held until next load)
//               busy   out  1  count != 0
//               tick   out  1  one-cycle pulse on each decrement
//
// Revision    : 1.0  initial release
// ============================================================================
module ampel_timer #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] init,
    output logic [4:0] count,
    output logic       ready,
    output logic       busy,
    output logic       tick
);

    // Prescaler value on the last cycle of a tick period.
    localparam logic [DIV_W-1:0] C_PRESC_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [4:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             tick_q,  tick_d;

    // Next-state logic. Load has priority over counting; reset is applied
    // in the register block and overrides both.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        ready_d = ready_q;
        tick_d  = 1'b0;

        if (load) begin
            // Restart the phase, also when a phase is still running. A zero
            // length completes immediately without producing a tick.
            count_d = init;
            presc_d = '0;
            ready_d = (init == 5'd0);
        end else if (count_q != 5'd0) begin
            if (presc_q == C_PRESC_LAST) begin
                presc_d = '0;
                count_d = count_q - 5'd1;
                tick_d  = 1'b1;
                // Raise ready on the same edge that count reaches zero.
                if (count_q == 5'd1) begin
                    ready_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else begin
            // Idle: prescaler parked at zero, ready keeps its last value.
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= 5'd0;
            ready_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            ready_q <= ready_d;
            tick_q  <= tick_d;
        end
    end

    assign count = count_q;
    assign ready = ready_q;
    assign tick  = tick_q;
    assign busy  = (count_q != 5'd0);

endmodule
`default_nettype wire
